// File: rtl/adder_seq_pkg.sv
// adder_seq_pkg
// Shared definitions for the digit-serial adder sequencer.
//   SLICE_W : width of the shared adder slice (one nibble)
//   state_t : sequencer states IDLE / RUN / DONE
//   nslice  : number of slice passes needed for a given operand width
package adder_seq_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int nslice(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/adder_slice4.sv
// adder_slice4
// Purely combinational 4-bit adder slice with carry-in and carry-out.
// Ports:
//   a, b  : input  [3:0]  nibble operands
//   cin   : input        carry-in
//   s     : output [3:0]  nibble sum
//   cout  : output       carry-out
module adder_slice4
  import adder_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  logic [SLICE_W:0] total;

  // Widen by one bit so the carry-out falls out of the top of the sum
  assign total = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
  assign s     = total[SLICE_W-1:0];
  assign cout  = total[SLICE_W];

endmodule

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl
// Digit-serial add sequencer: two requesters share one 4-bit adder slice.
// An accepted WIDTH-bit add (a + b + cin) is walked through the slice one
// nibble per cycle, LSB first, with the inter-nibble carry held in a single
// register. The full sum and carry-out are returned on a response channel.
//
// Optional feature macro: ADDER_SEQ_RR_EN
//   defined   -> round-robin arbitration between the two requesters
//   undefined -> fixed priority, requester 0 wins; no pointer register
//
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   req0_valid/req0_ready : requester 0 handshake
//   req0_a, req0_b        : requester 0 operands [WIDTH-1:0]
//   req0_cin              : requester 0 carry-in
//   req1_*                : same set for requester 1
//   rsp_valid/rsp_ready   : response handshake
//   rsp_sum               : (a + b + cin) mod 2^WIDTH
//   rsp_cout              : bit WIDTH of a + b + cin
//   rsp_id                : requester that issued the result
module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int WIDTH = 16
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id
);

  localparam int NSLICE = nslice(WIDTH);
  // Keep the index at least one bit wide so WIDTH=4 still elaborates
  localparam int IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_t             state;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic               grant;
  logic               accept;
  logic [SLICE_W-1:0] nib_a;
  logic [SLICE_W-1:0] nib_b;
  logic [SLICE_W-1:0] nib_s;
  logic               nib_cout;

`ifdef ADDER_SEQ_RR_EN
  logic ptr;

  // The pointer only decides ties; a lone valid requester always wins
  always_comb begin
    grant = !req0_valid;
    if (req0_valid && req1_valid) begin
      grant = ptr;
    end
  end
`else
  // Fixed priority: requester 1 is chosen only when requester 0 is idle
  assign grant = !req0_valid;
`endif

  // Gating with the requester's own valid keeps ready low for idle requesters
  // and guarantees at most one ready per cycle
  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  // Nibble select feeding the shared slice
  assign nib_a = a_reg[int'(idx)*SLICE_W +: SLICE_W];
  assign nib_b = b_reg[int'(idx)*SLICE_W +: SLICE_W];

  adder_slice4 u_slice (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry),
    .s    (nib_s),
    .cout (nib_cout)
  );

  // Sequencer FSM: capture operands on accept, one slice pass per RUN cycle,
  // then hold the registered response in DONE until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= 1'b0;
`ifdef ADDER_SEQ_RR_EN
      ptr       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg  <= grant ? req1_a : req0_a;
            b_reg  <= grant ? req1_b : req0_b;
            carry  <= grant ? req1_cin : req0_cin;
            rsp_id <= grant;
            idx    <= '0;
            state  <= RUN;
`ifdef ADDER_SEQ_RR_EN
            ptr    <= !grant;
`endif
          end
        end
        RUN: begin
          rsp_sum[int'(idx)*SLICE_W +: SLICE_W] <= nib_s;
          carry <= nib_cout;
          idx   <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            rsp_cout  <= nib_cout;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl
// Directed self-checking bench for adder_seq_ctrl (WIDTH=16).
// Expected results follow the round-robin or fixed-priority behaviour
// depending on whether ADDER_SEQ_RR_EN is defined for the build.
module tb_adder_seq_ctrl;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid = 1'b0;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a = '0;
  logic [WIDTH-1:0] req0_b = '0;
  logic             req0_cin = 1'b0;
  logic             req1_valid = 1'b0;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a = '0;
  logic [WIDTH-1:0] req1_b = '0;
  logic             req1_cin = 1'b0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_cout;
  logic             rsp_id;

  int total = 0;
  int bad = 0;
  int dual_grants = 0;
  int idle_readies = 0;

  adder_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_id     (rsp_id)
  );

  always #5 clk = ~clk;

  // Grant monitor, sampled well after inputs settle
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (req0_ready && req1_ready) dual_grants++;
      if ((req0_ready && !req0_valid) || (req1_ready && !req1_valid)) idle_readies++;
    end
  end

  // Global watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Count one comparison and report a mismatch
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Present a request from one requester and complete its handshake.
  // Called just after a falling edge; returns #1 after the accepting edge.
  task automatic applyStimulus(input bit id, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input bit cin);
    bit got_ready;
    got_ready = 1'b0;
    if (id) begin
      req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      #1;
      if (id ? req1_ready : req0_ready) begin
        got_ready = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got_ready) checkOutput("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (id) req1_valid = 1'b0;
    else req0_valid = 1'b0;
  endtask

  // Count falling edges until rsp_valid is seen, with a bounded budget
  task automatic waitRsp(output int lat);
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    if (!rsp_valid) checkOutput("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat;
    int stale;
    bit exp_id;

    // Reset with random inputs applied
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req0_valid = 1'($urandom);
      req1_valid = 1'($urandom);
      req0_a = 16'($urandom); req0_b = 16'($urandom); req0_cin = 1'($urandom);
      req1_a = 16'($urandom); req1_b = 16'($urandom); req1_cin = 1'($urandom);
      rsp_ready = 1'($urandom);
    end
    #1;
    checkOutput("reset_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_sum", 32'(rsp_sum), 32'd0);
    checkOutput("reset_cout", 32'(rsp_cout), 32'd0);
    checkOutput("reset_id", 32'(rsp_id), 32'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add with a carry across the low byte, latency check
    applyStimulus(1'b0, 16'h00FF, 16'h0001, 1'b0);
    waitRsp(lat);
    checkOutput("basic_lat", 32'(lat), 32'd5);
    checkOutput("basic_sum", 32'(rsp_sum), 32'h0100);
    checkOutput("basic_cout", 32'(rsp_cout), 32'd0);
    checkOutput("basic_id", 32'(rsp_id), 32'd0);
    @(negedge clk);

    // Full carry ripple from requester 1
    applyStimulus(1'b1, 16'hFFFF, 16'h0001, 1'b0);
    waitRsp(lat);
    checkOutput("ripple_sum", 32'(rsp_sum), 32'h0000);
    checkOutput("ripple_cout", 32'(rsp_cout), 32'd1);
    checkOutput("ripple_id", 32'(rsp_id), 32'd1);
    @(negedge clk);

    // Carry-in alone drives the ripple
    applyStimulus(1'b1, 16'hFFFF, 16'h0000, 1'b1);
    waitRsp(lat);
    checkOutput("cin_sum", 32'(rsp_sum), 32'h0000);
    checkOutput("cin_cout", 32'(rsp_cout), 32'd1);
    checkOutput("cin_id", 32'(rsp_id), 32'd1);
    @(negedge clk);

    // Both requesters valid continuously
    req0_a = 16'h1111; req0_b = 16'h2222; req0_cin = 1'b0; req0_valid = 1'b1;
    req1_a = 16'hF000; req1_b = 16'h1000; req1_cin = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef ADDER_SEQ_RR_EN
      exp_id = 1'(k % 2);
`else
      exp_id = 1'b0;
`endif
      waitRsp(lat);
      if (k > 0) checkOutput("both_gap", 32'(lat), 32'd6);
      checkOutput("both_id", 32'(rsp_id), 32'(exp_id));
      checkOutput("both_sum", 32'(rsp_sum), exp_id ? 32'h0001 : 32'h3333);
      checkOutput("both_cout", 32'(rsp_cout), exp_id ? 32'd1 : 32'd0);
      if (k == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
    @(negedge clk);

    // Backpressure: hold the response for three cycles
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 16'h1234, 16'h4321, 1'b0);
    waitRsp(lat);
    req1_a = 16'h0001; req1_b = 16'h0001; req1_cin = 1'b0; req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #3;
      checkOutput("bp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_sum", 32'(rsp_sum), 32'h5555);
      checkOutput("bp_readies", 32'({req0_ready, req1_ready}), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    checkOutput("bp_valid_4th", 32'(rsp_valid), 32'd1);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    checkOutput("bp_released", 32'(rsp_valid), 32'd0);
    @(negedge clk);

    // Reset during the second RUN cycle aborts the operation
    applyStimulus(1'b0, 16'h1234, 16'h1111, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_valid", 32'(rsp_valid), 32'd0);
    checkOutput("abort_sum", 32'(rsp_sum), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) stale++;
    end
    checkOutput("abort_stale", 32'(stale), 32'd0);
    applyStimulus(1'b0, 16'h8000, 16'h8000, 1'b0);
    waitRsp(lat);
    checkOutput("post_lat", 32'(lat), 32'd5);
    checkOutput("post_sum", 32'(rsp_sum), 32'h0000);
    checkOutput("post_cout", 32'(rsp_cout), 32'd1);
    checkOutput("post_id", 32'(rsp_id), 32'd0);
    @(negedge clk);
    @(negedge clk);

    checkOutput("dual_grants", 32'(dual_grants), 32'd0);
    checkOutput("idle_readies", 32'(idle_readies), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
